// File: rtl/vc_skid_buf_pkg.sv
// Shared types and constants for the two-entry val/rdy skid buffer.
package vc_skid_pkg;

    // Number of messages the buffer can hold (head + skid).
    localparam int SKID_DEPTH = 2;

    // Occupancy-coded state: the encoding doubles as num_entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/vc_skid_buf_if.sv
// Enqueue/dequeue handshake bundle for vc_skid_buf.
// slave  : the buffer side (accepts on enq_*, presents on deq_*).
// master : the surrounding producer/consumer side.
interface vc_skid_buf_if
    import vc_skid_pkg::*;
#(
    parameter int p_nbits = 32
);

    logic                                enq_val;
    logic                                enq_rdy;
    logic [p_nbits-1:0]                  enq_msg;
    logic                                deq_val;
    logic                                deq_rdy;
    logic [p_nbits-1:0]                  deq_msg;
    logic [$clog2(SKID_DEPTH+1)-1:0]     num_entries;

    modport slave (
        input  enq_val, enq_msg, deq_rdy,
        output enq_rdy, deq_val, deq_msg, num_entries
    );

    modport master (
        output enq_val, enq_msg, deq_rdy,
        input  enq_rdy, deq_val, deq_msg, num_entries
    );

endinterface

// File: rtl/vc_skid_buf_regs.sv
// Basic register primitives used by the skid buffer: a register with
// synchronous reset (for control state) and an enabled register without
// reset (for message payload storage).

module vc_ResetReg #(
    parameter int                 p_nbits       = 1,
    parameter logic [p_nbits-1:0] p_reset_value = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [p_nbits-1:0] d,
    output logic [p_nbits-1:0] q
);

    // Capture d every cycle; synchronous reset takes priority.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (reset)
            q <= p_reset_value;
        else
            q <= d;
    end

endmodule

module vc_EnReg #(
    parameter int p_nbits = 1
) (
    input  logic               clk,
    input  logic               en,
    input  logic [p_nbits-1:0] d,
    output logic [p_nbits-1:0] q
);

    // Load d only when enabled; contents are qualified by valid state elsewhere.
    always_ff @(posedge clk) begin
        // NOTE: payload storage is not reset; its value is ignored until the
        // control state marks it valid, so a reset would only cost wiring.
        if (en)
            q <= d;
    end

endmodule

// File: rtl/vc_skid_buf.sv
// Two-entry val/rdy skid buffer. Messages land in 'main' (driven onto
// deq_msg) one cycle after enqueue; a second message arriving while the
// consumer stalls is parked in 'skid'. enq_rdy depends only on registered
// state and reset, never on deq_rdy, which is what breaks the ready path.
module vc_skid_buf
    import vc_skid_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic          clk,
    input  logic          reset,
    vc_skid_buf_if.slave  bus
);

    logic [1:0]         state_bits;
    skid_state_t        state;
    skid_state_t        state_next;

    logic               enq_rdy;
    logic               deq_val;
    logic               enq_fire;
    logic               deq_fire;

    logic               main_en;
    logic               skid_en;
    logic [p_nbits-1:0] main_d;
    logic [p_nbits-1:0] main_q;
    logic [p_nbits-1:0] skid_q;

    vc_ResetReg #(
        .p_nbits       (2),
        .p_reset_value (EMPTY)
    ) state_reg (
        .clk   (clk),
        .reset (reset),
        .d     (state_next),
        .q     (state_bits)
    );

    assign state = skid_state_t'(state_bits);

    vc_EnReg #(.p_nbits(p_nbits)) main_reg (
        .clk (clk),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    vc_EnReg #(.p_nbits(p_nbits)) skid_reg (
        .clk (clk),
        .en  (skid_en),
        .d   (bus.enq_msg),
        .q   (skid_q)
    );

    assign enq_rdy  = (state != FULL) && !reset;
    assign deq_val  = (state != EMPTY);
    assign enq_fire = bus.enq_val && enq_rdy;
    assign deq_fire = deq_val && bus.deq_rdy;

    // Next-state and register-enable decode from the two fire conditions.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no branch
        // can leave it unassigned and infer a latch.
        state_next = state;
        main_en    = 1'b0;
        skid_en    = 1'b0;
        main_d     = bus.enq_msg;

        case (state)
            EMPTY: begin
                if (enq_fire) begin
                    state_next = ONE;
                    main_en    = 1'b1;
                end
            end
            ONE: begin
                if (enq_fire && deq_fire) begin
                    main_en    = 1'b1;
                end else if (enq_fire) begin
                    state_next = FULL;
                    skid_en    = 1'b1;
                end else if (deq_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (deq_fire) begin
                    state_next = ONE;
                    main_en    = 1'b1;
                    main_d     = skid_q;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    assign bus.enq_rdy     = enq_rdy;
    assign bus.deq_val     = deq_val;
    assign bus.deq_msg     = main_q;
    assign bus.num_entries = state_bits;

endmodule

// File: tb/tb_vc_skid_buf.sv
// Self-checking bench for vc_skid_buf. A queue holds what the buffer should
// contain; each cycle the outputs are compared against the queue's size and
// head, then the queue is updated from the fire decisions the queue implies.
module tb_vc_skid_buf;
    import vc_skid_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vc_skid_buf_if #(.p_nbits(32)) bus ();

    vc_skid_buf #(.p_nbits(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] model[$];
    bit          model_valid = 1'b0;
    bit          last_efire  = 1'b0;
    bit          stall_prev  = 1'b0;
    logic [31:0] held_msg    = '0;
    string       phase       = "init";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s/%s: observed %h expected %h", phase, tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance.
    task automatic cycle(input logic rs, input logic ev, input logic [31:0] em, input logic dr);
        int sz;
        bit efire;
        bit dfire;
        reset       = rs;
        bus.enq_val = ev;
        bus.enq_msg = em;
        bus.deq_rdy = dr;
        #1;
        sz = model.size();
        if (rs) begin
            check("enq_rdy_in_reset", {31'd0, bus.enq_rdy}, 32'd0);
        end else if (model_valid) begin
            check("enq_rdy", {31'd0, bus.enq_rdy}, {31'd0, sz < SKID_DEPTH});
            check("deq_val", {31'd0, bus.deq_val}, {31'd0, sz > 0});
            check("num_entries", {30'd0, bus.num_entries}, sz);
            if (sz > 0)
                check("deq_msg", bus.deq_msg, model[0]);
            if (stall_prev)
                check("deq_msg_stable", bus.deq_msg, held_msg);
        end
        efire      = ev && !rs && model_valid && (sz < SKID_DEPTH);
        dfire      = dr && !rs && (sz > 0);
        stall_prev = !rs && (sz > 0) && !dr;
        if (sz > 0)
            held_msg = model[0];
        @(posedge clk);
        if (rs) begin
            model.delete();
            model_valid = 1'b1;
        end else begin
            if (dfire)
                void'(model.pop_front());
            if (efire)
                model.push_back(em);
        end
        last_efire = efire;
        @(negedge clk);
    endtask

    // Offer one message and keep it stable until accepted (bounded).
    task automatic send(input logic [31:0] m, input logic dr);
        int tries = 0;
        do begin
            cycle(1'b0, 1'b1, m, dr);
            tries++;
        end while (!last_efire && tries < 8);
        check("send_accepted", {31'd0, last_efire}, 32'd1);
    endtask

    initial begin
        logic [31:0] m;
        bit          ev;
        bit          dr;
        bit          hold;

        reset       = 1'b1;
        bus.enq_val = 1'b0;
        bus.enq_msg = '0;
        bus.deq_rdy = 1'b0;
        @(negedge clk);

        phase = "reset";
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        phase = "post_reset";
        cycle(1'b0, 1'b0, 32'h0, 1'b0);

        phase = "stream";
        send(32'h11, 1'b1);
        send(32'h22, 1'b1);
        send(32'h33, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        phase = "fill";
        cycle(1'b0, 1'b1, 32'hA, 1'b0);
        cycle(1'b0, 1'b1, 32'hB, 1'b0);
        cycle(1'b0, 1'b1, 32'hC, 1'b0);
        cycle(1'b0, 1'b1, 32'hC, 1'b0);

        phase = "drain";
        send(32'hC, 1'b1);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 32'h0, 1'b1);

        phase = "skid";
        for (int i = 0; i < 10; i++)
            send(32'h100 + i, (i != 4));
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 32'h0, 1'b1);

        phase = "reset_full";
        cycle(1'b0, 1'b1, 32'h55, 1'b0);
        cycle(1'b0, 1'b1, 32'h66, 1'b0);
        cycle(1'b0, 1'b1, 32'h77, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        phase = "random";
        hold = 1'b0;
        m    = '0;
        for (int i = 0; i < 1000; i++) begin
            if (hold) begin
                ev = 1'b1;
            end else begin
                ev = 1'($urandom_range(0, 1));
                m  = $urandom;
            end
            dr = 1'($urandom_range(0, 1));
            cycle(1'b0, ev, m, dr);
            hold = ev && !last_efire;
        end
        phase = "final_drain";
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b0, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
